// File: rtl/fp32_pkg.sv
// IEEE-754 single-precision field layout, constants and classification helpers
// shared by the divider and its streaming front/back end.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic {OS_EMPTY, OS_FULL} out_state_e;

  function automatic logic is_zero(input fp32_t x);
    return (x.exp == '0) && (x.frac == '0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac == '0);
  endfunction

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac != '0);
  endfunction

endpackage

// File: rtl/div.sv
// Combinational FP32 divider, round-to-nearest-even, subnormal inputs read as
// zero, results that leave the normal range saturate to inf or flush to zero.
module div
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        overflow,
  output logic        underflow
);

  fp32_t       fa, fb;
  logic        sign, a_zero, b_zero;
  logic [48:0] num, den, quo_full, rem_full;
  logic [25:0] quo;
  logic        hi, guard, sticky, inc;
  logic [23:0] mant;
  logic [24:0] mant_r;
  logic [22:0] frac_r;
  logic        unused_bits;
  int          res_exp;

  assign fa     = a;
  assign fb     = b;
  assign sign   = fa.sign ^ fb.sign;
  assign a_zero = (fa.exp == '0);
  assign b_zero = (fb.exp == '0);

  // Mantissa ratio lies in (0.5, 2); 25 extra bits leave a guard bit either way.
  assign num      = {1'b1, fa.frac, 25'd0};
  assign den      = {25'd0, 1'b1, fb.frac};
  assign quo_full = num / den;
  assign rem_full = num % den;
  assign quo      = quo_full[25:0];

  assign hi     = quo[25];
  assign mant   = hi ? quo[25:2] : quo[24:1];
  assign guard  = hi ? quo[1] : quo[0];
  assign sticky = (hi & quo[0]) | (|rem_full);
  assign inc    = guard & (sticky | mant[0]);
  assign mant_r = {1'b0, mant} + {24'd0, inc};
  assign frac_r = mant_r[24] ? '0 : mant_r[22:0];

  assign unused_bits = ^{quo_full[48:26], mant_r[23]};

  // NOTE: every output gets a default first so no path through the branches infers a latch.
  always_comb begin
    q         = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    res_exp   = int'(fa.exp) - int'(fb.exp) + BIAS - int'(!hi) + int'(mant_r[24]);
    if (is_nan(fa) || is_nan(fb) || (is_inf(fa) && is_inf(fb)) || (a_zero && b_zero)) begin
      q = QNAN;
    end else if (is_inf(fa) || b_zero) begin
      q = {sign, EXP_MAX, 23'd0};
    end else if (a_zero || is_inf(fb)) begin
      q = {sign, 31'd0};
    end else if (res_exp >= 255) begin
      q        = {sign, EXP_MAX, 23'd0};
      overflow = 1'b1;
    end else if (res_exp <= 0) begin
      q         = {sign, 31'd0};
      underflow = 1'b1;
    end else begin
      q = {sign, res_exp[7:0], frac_r};
    end
  end

endmodule

// File: rtl/fp_div_fifo.sv
// Power-of-two operand FIFO with occupancy count and synchronous flush;
// the head entry is presented combinationally on rdata_o.
module fp_div_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fp_div_issue.sv
// Streams operand pairs through a FIFO into the combinational divider and
// captures each quotient in a back-pressurable output register.
module fp_div_issue
  import fp32_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_dz,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t        head;
  fp32_t      head_a, head_b;
  logic       head_valid, load, head_dz;
  logic [31:0] div_q;
  logic       div_ovf, div_unf;
  out_state_e state_q;

  assign in_ready   = (count != FULL_CNT);
  assign head_valid = (count != '0);
  assign load       = head_valid && ((state_q == OS_EMPTY) || out_ready);
  assign out_valid  = (state_q == OS_FULL);

  fp_div_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(op_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (in_valid && in_ready),
    .wdata_i ({in_a, in_b, in_tag}),
    .pop_i   (load),
    .rdata_o (head),
    .count_o (count)
  );

  assign head_a  = head.a;
  assign head_b  = head.b;
  // Finite nonzero over a true zero; the quotient itself still comes from the divider.
  assign head_dz = is_zero(head_b) && (head_a.exp != EXP_MAX) && !is_zero(head_a);

  div u_div (
    .a         (head.a),
    .b         (head.b),
    .q         (div_q),
    .overflow  (div_ovf),
    .underflow (div_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= OS_EMPTY;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_dz        <= 1'b0;
      out_tag       <= '0;
    end else if (flush) begin
      state_q <= OS_EMPTY;
    end else if (load) begin
      state_q       <= OS_FULL;
      out_result    <= div_q;
      out_overflow  <= div_ovf;
      out_underflow <= div_unf;
      out_dz        <= head_dz;
      out_tag       <= head.tag;
    end else if ((state_q == OS_FULL) && out_ready) begin
      state_q <= OS_EMPTY;
    end
  end

endmodule

// File: doc/fp_div_issue.md
Name: fp_div_issue

Overview:
Sequential front/back end for the combinational FP32 divider `div`. It accepts operand pairs on a valid/ready stream and buffers them in a DEPTH-entry FIFO. The FIFO head is presented to a `div` instance, and each quotient with its overflow/underflow flags and tag is captured into a registered, back-pressurable output stage. It is the stage that feeds `div` and consumes its result, and it turns the divider into a pipelined stream unit with throughput of 1 per cycle.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, ≥2)
TAG_W, 4, width of the user tag carried alongside each operation

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous clear of FIFO and output stage
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept
in_a  in  32  dividend, IEEE-754 single
in_b  in  32  divisor, IEEE-754 single
in_tag  in  TAG_W  user tag
out_valid  out  1  result register holds a result
out_ready  in  1  consumer accepts
out_result  out  32  quotient from `div`
out_overflow  out  1  `div` overflow flag
out_underflow  out  1  `div` underflow flag
out_dz  out  1  divide-by-zero: B is ±0 and A is finite nonzero
out_tag  out  TAG_W  tag of this result
count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, count=0, out_valid=0, out_result=0, all flags=0, out_tag=0; in_ready=1 after release. Reset mid-operation discards all queued and held results.
- Push: in_valid & in_ready at an edge writes {a,b,tag} at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on count, with no combinational path from out_ready.
- FIFO head (rd_ptr entry) drives `div`.A/B combinationally whenever count≠0.
- Output stage, two states:
  - EMPTY (out_valid=0): if count≠0, load the head result and go to FULL.
  - FULL (out_valid=1):
    - out_ready=1 and count≠0: reload with next head, stay FULL.
    - out_ready=1 and count=0: go to EMPTY.
    - out_ready=0: hold all outputs stable.
- Pop occurs exactly when the output stage loads; rd_ptr wraps modulo DEPTH.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including at count=DEPTH−1 and when a full FIFO pops while in_ready=0 (no push possible that cycle).
- Latency: pair accepted at edge N → out_valid high after edge N+1 (2 edges), if the output stage was EMPTY or drained.
- Throughput: one result per cycle with out_ready held high.
- out_dz: computed locally from the head operands.
  - Condition: B exp=0 and frac=0, and A exp≠0xFF, and A not ±0.
  - It does not alter out_result.
- NaN, INF and 0/0 results pass through from `div` unchanged.
- flush=1 at an edge: count=0, pointers=0, out_valid=0. A push in the same cycle is dropped. flush has priority over push, pop and load.
- No output changes while out_valid=1 and out_ready=0; the outputs are stable under back-pressure.

Decomposition:
- Shared package fp32_pkg:
  - Field localparams: EXP_W=8, FRAC_W=23, BIAS=127.
  - Constants: EXP_MAX=8'hFF, POS_INF=32'h7F800000, NEG_INF=32'hFF800000.
  - Functions is_zero, is_inf, is_nan.
  - typedef fp32_t packed struct {sign, exp, frac}.
  - typedef out_state_e {OS_EMPTY, OS_FULL}.
- Natural sub-module: fp_div_fifo (parameterised DEPTH/width, push/pop/count/flush).
- Instantiates the existing `div` unchanged.

Test Plan:
- Single op, out_ready=1: A=0x40C00000 (6.0), B=0x40000000 (2.0), tag=3 → 2 edges later out_valid=1, out_result=0x40400000, flags 0, out_tag=3.
- Signs: A=0xC0600000 (−3.5), B=0xBFA00000 (−1.25) → out_result=0x40333333 (2.8), overflow=underflow=dz=0.
- Divide-by-zero: A=0xC4FC74CD (−2019.65), B=0 → out_result=0xFF800000, out_dz=1. A=0, B=0 → NaN passed through from `div`, out_dz=0.
- Back-pressure/full: hold out_ready=0 and push 5 ops with tags 0–4.
  - Expected: tag 0 sits in the output register and tags 1–4 fill the FIFO (count=4, in_ready=0).
  - Outputs remain stable while out_ready=0.
  - Release out_ready → tags 0,1,2,3,4 emerge in order on consecutive cycles.
- Wrap-around: stream 3×DEPTH ops with in_valid=out_ready=1 continuously → one result per cycle, tags in order, count≤1 throughout.
- Flush and reset: with count=3 and out_valid=1, assert flush for 1 cycle → count=0, out_valid=0, the next op has 2-edge latency. Repeat with rst_n pulsed low between edges → all outputs 0 immediately, asynchronously.
